pc_unit: RTL and testbench
==========================

PC_UNIT -- requirements
Module: pc_unit

Interface
REQ-001 Parameter WIDTH, default 16, address/PC width in bits.
REQ-002 Parameter STACK_DEPTH, default 8, return-address stack entries (power of two, >=2).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 hold  input  1  freeze PC and stack this cycle.
REQ-006 call  input  1  push return address, jump to load_addr.
REQ-007 ret  input  1  pop return address into PC.
REQ-008 load  input  1  jump to load_addr.
REQ-009 inc  input  1  advance PC by one.
REQ-010 load_addr  input  WIDTH  jump/call target.
REQ-011 pc  output  WIDTH  current program counter, registered.
REQ-012 stack_empty  output  1  high when stack holds zero entries.
REQ-013 stack_full  output  1  high when stack holds STACK_DEPTH entries.
REQ-014 stack_err  output  1  one-cycle pulse on overflow/underflow attempt.

Function
REQ-015 The block SHALL evaluate controls with fixed priority hold > call > ret > load > inc; only the highest asserted control acts.
REQ-016 All outputs SHALL be registered; a control sampled at edge N SHALL be visible on pc at edge N (one-cycle latency from input setup).
REQ-017 With no control asserted, pc and stack SHALL retain their values.
REQ-018 inc SHALL set pc to (pc+1) mod 2^WIDTH; 16'hFFFF SHALL wrap to 16'h0000 with no flag.
REQ-019 load SHALL set pc to load_addr; stack unchanged.
REQ-020 call with stack not full SHALL push (pc+1) mod 2^WIDTH, increment entry count, set pc to load_addr.
REQ-021 call with stack full SHALL leave pc and stack unchanged and pulse stack_err for one cycle.
REQ-022 ret with stack not empty SHALL set pc to top entry and decrement entry count.
REQ-023 ret with stack empty SHALL leave pc unchanged and pulse stack_err for one cycle.
REQ-024 stack_err SHALL be low in every cycle not covered by REQ-021/REQ-023.
REQ-025 hold SHALL suppress every other control, including error generation.
REQ-026 stack_empty/stack_full SHALL reflect the entry count after the edge, never both high.
REQ-027 Stack SHALL be LIFO; N pushes followed by N pops SHALL return addresses in reverse order.

Reset
REQ-028 rst_n low SHALL immediately force pc=0, entry count=0, stack_empty=1, stack_full=0, stack_err=0, independent of clk.
REQ-029 Reset asserted mid-operation SHALL discard all stack contents; first edge after release SHALL act on sampled controls normally.
REQ-030 Stack storage contents need not be reset; only count/pointer.

Configuration
REQ-031 Macro PC_CALL_STACK_EN defined: stack, call/ret behaviour and flags per REQ-020..REQ-027.
REQ-032 Macro PC_CALL_STACK_EN undefined: no stack storage; call SHALL behave as load (same priority slot), ret SHALL be ignored (falls through to load/inc), stack_empty tied 1, stack_full tied 0, stack_err tied 0.

Verification
REQ-033 Reset, then inc for 3 cycles -> pc 0,1,2,3; rst_n low asynchronously mid-cycle -> pc=0 before next edge.
REQ-034 load load_addr=16'hFFFE, then inc x2 -> pc 16'hFFFE, 16'hFFFF, 16'h0000, stack_err=0.
REQ-035 pc=16'h0010, call load_addr=16'h0100, call load_addr=16'h0200, ret, ret -> pc 16'h0100, 16'h0200, 16'h0101, 16'h0011; stack_empty=1 at end.
REQ-036 STACK_DEPTH=8: 8 calls -> stack_full=1; 9th call -> pc unchanged, stack_err pulses once; ret from empty -> pc unchanged, stack_err pulses once.
REQ-037 hold+call+inc with load_addr=16'h1234 -> pc and count unchanged; call+ret+load+inc together -> call wins.
REQ-038 Build without PC_CALL_STACK_EN: call load_addr=16'h0040 -> pc=16'h0040; ret+inc -> pc=16'h0041; flags constant 1/0/0.

Source files
------------

// File: rtl/pc_unit.sv
// ---------------------------------------------------------------------------
// pc_unit -- program counter with an optional return-address stack.
//
// Controls are prioritised hold > call > ret > load > inc. Only the highest
// asserted control acts, and the result shows on pc after the next rising
// edge. All outputs come straight from flops.
//
// Optional feature macro: PC_CALL_STACK_EN
//   defined   : LIFO return stack of STACK_DEPTH entries. call pushes pc+1
//               and jumps. ret pops into pc. Overflow and underflow leave
//               the state alone and pulse stack_err for one cycle.
//   undefined : no stack. call acts as load, ret is ignored (lower-priority
//               controls still act), and the flags are constant 1/0/0.
//
// Ports
//   clk         in   clock, rising edge
//   rst_n       in   async active-low reset
//   hold        in   freeze pc/stack this cycle (also blocks errors)
//   call        in   push return address, jump to load_addr
//   ret         in   pop return address into pc
//   load        in   jump to load_addr
//   inc         in   pc <= pc + 1 (wraps silently)
//   load_addr   in   [WIDTH] jump/call target
//   pc          out  [WIDTH] current program counter
//   stack_empty out  stack holds zero entries
//   stack_full  out  stack holds STACK_DEPTH entries
//   stack_err   out  one-cycle overflow/underflow pulse
// ---------------------------------------------------------------------------
module pc_unit #(
    parameter int WIDTH       = 16,
    parameter int STACK_DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             hold,
    input  logic             call,
    input  logic             ret,
    input  logic             load,
    input  logic             inc,
    input  logic [WIDTH-1:0] load_addr,
    output logic [WIDTH-1:0] pc,
    output logic             stack_empty,
    output logic             stack_full,
    output logic             stack_err
);

    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] pc_inc;

    assign pc_inc = pc_q + WIDTH'(1);
    assign pc     = pc_q;

`ifdef PC_CALL_STACK_EN
    localparam int PW = $clog2(STACK_DEPTH);

    // The count is one bit wider than the pointer so that "full" can be told
    // apart from "empty".
    logic [PW:0]      cnt_q, cnt_d;
    logic             empty_q, empty_d;
    logic             full_q, full_d;
    logic             err_q, err_d;
    logic             push;
    logic [PW-1:0]    wr_idx, top_idx;
    logic [WIDTH-1:0] stack_q [STACK_DEPTH];

    assign wr_idx  = cnt_q[PW-1:0];
    assign top_idx = PW'(cnt_q - (PW+1)'(1));

    always_comb begin
        pc_d  = pc_q;
        cnt_d = cnt_q;
        err_d = 1'b0;
        push  = 1'b0;
        if (hold) begin
            // hold freezes everything, including error generation
        end else if (call) begin
            if (full_q) begin
                err_d = 1'b1;
            end else begin
                push  = 1'b1;
                cnt_d = cnt_q + (PW+1)'(1);
                pc_d  = load_addr;
            end
        end else if (ret) begin
            if (empty_q) begin
                err_d = 1'b1;
            end else begin
                pc_d  = stack_q[top_idx];
                cnt_d = cnt_q - (PW+1)'(1);
            end
        end else if (load) begin
            pc_d = load_addr;
        end else if (inc) begin
            pc_d = pc_inc;
        end
        // The flags are decoded from the next count so that they are
        // registered alongside it.
        empty_d = (cnt_d == '0);
        full_d  = (cnt_d == (PW+1)'(STACK_DEPTH));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q    <= '0;
            cnt_q   <= '0;
            empty_q <= 1'b1;
            full_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
            empty_q <= empty_d;
            full_q  <= full_d;
            err_q   <= err_d;
        end
    end

    // The storage is not reset. A cleared count makes the old entries
    // unreachable.
    always_ff @(posedge clk) begin
        if (push) begin
            stack_q[wr_idx] <= pc_inc;
        end
    end

    assign stack_empty = empty_q;
    assign stack_full  = full_q;
    assign stack_err   = err_q;
`else
    // Without a stack, call takes the place of load, and ret falls through.
    always_comb begin
        pc_d = pc_q;
        if (hold) begin
            pc_d = pc_q;
        end else if (call || load) begin
            pc_d = load_addr;
        end else if (inc) begin
            pc_d = pc_inc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= '0;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign stack_empty = 1'b1;
    assign stack_full  = 1'b0;
    assign stack_err   = 1'b0;
`endif

endmodule

// File: tb/tb_pc_unit.sv
// ---------------------------------------------------------------------------
// tb_pc_unit -- scoreboard bench for pc_unit (WIDTH=16, STACK_DEPTH=8).
// The stimulus drives its controls on a falling edge. After the rising edge
// that consumes them, it pushes the hand-computed expected outputs. The
// monitor pops one entry on each falling edge and compares it with the DUT.
// ---------------------------------------------------------------------------
module tb_pc_unit;

    typedef struct packed {
        logic [15:0] pc;
        logic        empty;
        logic        full;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        hold = 1'b0, call = 1'b0, ret = 1'b0, load = 1'b0, inc = 1'b0;
    logic [15:0] load_addr = '0;
    logic [15:0] pc;
    logic        stack_empty, stack_full, stack_err;

    exp_t q[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    bit   stim_done = 1'b0;

    pc_unit #(.WIDTH(16), .STACK_DEPTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .hold(hold), .call(call), .ret(ret),
        .load(load), .inc(inc), .load_addr(load_addr), .pc(pc),
        .stack_empty(stack_empty), .stack_full(stack_full), .stack_err(stack_err)
    );

    always #5 clk = ~clk;

    // monitor
    initial begin : monitor
        exp_t e, a;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                a = '{pc, stack_empty, stack_full, stack_err};
                n_chk++;
                if (a !== e) begin
                    n_fail++;
                    $display("FAIL chk%0d t=%0t: got pc=%h e/f/err=%b%b%b, want pc=%h e/f/err=%b%b%b",
                             n_chk, $time, a.pc, a.empty, a.full, a.err,
                             e.pc, e.empty, e.full, e.err);
                end
            end
        end
    end

    task automatic step(input logic h, input logic c, input logic r, input logic l,
                        input logic i, input logic [15:0] addr,
                        input logic [15:0] epc, input logic ee, input logic ef,
                        input logic er);
        @(negedge clk);
        hold = h; call = c; ret = r; load = l; inc = i; load_addr = addr;
        @(posedge clk);
        #1;
        q.push_back('{epc, ee, ef, er});
    endtask

    task automatic idle_ctl();
        hold = 0; call = 0; ret = 0; load = 0; inc = 0;
    endtask

    // Assert reset part-way through a cycle. The monitor's next falling edge
    // comes before any rising edge, so it sees the asynchronous clear.
    task automatic async_reset();
        @(negedge clk);
        idle_ctl();
        @(posedge clk);
        #2 rst_n = 1'b0;
        #0 q.push_back('{16'h0000, 1'b1, 1'b0, 1'b0});
        @(negedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin : stim
        #1 q.push_back('{16'h0000, 1'b1, 1'b0, 1'b0});  // reset state
        @(negedge clk);
        #1 rst_n = 1'b1;

        // inc x3, then an asynchronous reset
        step(0,0,0,0,1, 16'h0000, 16'h0001, 1,0,0);
        step(0,0,0,0,1, 16'h0000, 16'h0002, 1,0,0);
        step(0,0,0,0,1, 16'h0000, 16'h0003, 1,0,0);
        async_reset();

        // load then wrap-around
        step(0,0,0,1,0, 16'hFFFE, 16'hFFFE, 1,0,0);
        step(0,0,0,0,1, 16'h0000, 16'hFFFF, 1,0,0);
        step(0,0,0,0,1, 16'h0000, 16'h0000, 1,0,0);
        step(0,0,0,0,0, 16'h5555, 16'h0000, 1,0,0);   // no control: retain

`ifdef PC_CALL_STACK_EN
        // nested call / ret
        step(0,0,0,1,0, 16'h0010, 16'h0010, 1,0,0);
        step(0,1,0,0,0, 16'h0100, 16'h0100, 0,0,0);
        step(0,1,0,0,0, 16'h0200, 16'h0200, 0,0,0);
        step(0,0,1,0,0, 16'h0000, 16'h0101, 0,0,0);
        step(0,0,1,0,0, 16'h0000, 16'h0011, 1,0,0);

        // fill the stack: call k pushes 0x0012 (k=0) or 0x1000+k, pc -> 0x1000+k
        for (int k = 0; k < 8; k++)
            step(0,1,0,0,0, 16'h1000 + 16'(k), 16'h1000 + 16'(k), 0, (k == 7), 0);
        step(0,1,0,0,0, 16'h2000, 16'h1007, 0,1,1);   // overflow
        step(0,0,0,0,0, 16'h0000, 16'h1007, 0,1,0);   // error pulse ends
        for (int k = 7; k >= 1; k--)
            step(0,0,1,0,0, 16'h0000, 16'h1000 + 16'(k), 0,0,0);
        step(0,0,1,0,0, 16'h0000, 16'h0012, 1,0,0);
        step(0,0,1,0,0, 16'h0000, 16'h0012, 1,0,1);   // underflow
        step(0,0,0,0,0, 16'h0000, 16'h0012, 1,0,0);

        // priority
        step(1,1,0,0,1, 16'h1234, 16'h0012, 1,0,0);   // hold wins
        step(1,0,1,0,0, 16'h0000, 16'h0012, 1,0,0);   // hold blocks underflow err
        step(0,1,1,1,1, 16'h0300, 16'h0300, 0,0,0);   // call wins, pushes 0x0013
        step(0,0,1,0,1, 16'h0000, 16'h0013, 1,0,0);   // ret beats inc

        // reset clears the stack
        step(0,1,0,0,0, 16'h0400, 16'h0400, 0,0,0);
        async_reset();
        step(0,0,1,0,0, 16'h0000, 16'h0000, 1,0,1);   // stack gone: underflow
`else
        // stackless build
        step(0,1,0,0,0, 16'h0040, 16'h0040, 1,0,0);   // call behaves as load
        step(0,0,1,0,1, 16'h0000, 16'h0041, 1,0,0);   // ret ignored, inc acts
        step(0,0,1,0,0, 16'h0000, 16'h0041, 1,0,0);   // ret alone: nothing
        step(0,0,1,1,0, 16'h0100, 16'h0100, 1,0,0);   // ret falls to load
        step(1,1,0,0,1, 16'h1234, 16'h0100, 1,0,0);   // hold wins
        step(0,1,1,1,1, 16'h0500, 16'h0500, 1,0,0);   // call slot wins
        step(0,0,0,0,1, 16'h0000, 16'h0501, 1,0,0);
`endif
        @(negedge clk);
        idle_ctl();
        stim_done = 1'b1;
    end

    initial begin : finisher
        int budget;
        budget = 0;
        while (!(stim_done && q.size() == 0) && budget < 2000) begin
            @(posedge clk);
            budget++;
        end
        @(negedge clk);
        #1;
        if (q.size() != 0 || !stim_done) begin
            n_chk++;
            n_fail++;
            $display("FAIL drain: %0d expected entries left unchecked, want 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
